// File: rtl/serial_pattern_tx.sv
// Loads a parallel pattern and sends its low len_eff bits MSB-first, one bit per clock.
// Supports gapless repeat, immediate abort, and a done pulse on each pass's last bit.
module serial_pattern_tx #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [3:0]       len,
   input  logic             repeat_en,
   input  logic             abort,
   output logic             d_out,
   output logic             d_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    len_reg;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    len_eff;

   // Returns v[n-1]; n ranges 1..WIDTH.
   function automatic logic pick(input logic [WIDTH-1:0] v, input logic [CW-1:0] n);
      logic b;
      b = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i + 1 == int'(n)) b = v[i];
      end
      return b;
   endfunction

   always_comb begin
      len_eff = CW'(WIDTH);
      if (len != 4'd0 && int'(len) <= WIDTH) len_eff = CW'(len);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         len_reg <= '0;
         cnt     <= '0;
         d_out   <= 1'b0;
         d_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (abort) begin
         state   <= IDLE;
         cnt     <= '0;
         d_out   <= 1'b0;
         d_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               d_out   <= 1'b0;
               d_valid <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               if (start) begin
                  state   <= SHIFT;
                  shreg   <= pattern;
                  len_reg <= len_eff;
                  cnt     <= len_eff;
                  d_out   <= pick(pattern, len_eff);
                  d_valid <= 1'b1;
                  busy    <= 1'b1;
                  done    <= (len_eff == CW'(1));
               end
            end
            SHIFT: begin
               if (cnt == CW'(1)) begin
                  // Repeat reloads from the captured copy, never from the live inputs.
                  if (repeat_en) begin
                     cnt   <= len_reg;
                     d_out <= pick(shreg, len_reg);
                     done  <= (len_reg == CW'(1));
                  end else begin
                     state   <= IDLE;
                     cnt     <= '0;
                     d_out   <= 1'b0;
                     d_valid <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b0;
                  end
               end else begin
                  cnt   <= cnt - CW'(1);
                  d_out <= pick(shreg, cnt - CW'(1));
                  done  <= (cnt == CW'(2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: stimulus queues expected {done,bit} pairs, a negedge monitor pops and compares.
module tb_serial_pattern_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [11:0] pattern = '0;
   logic [3:0]  len = '0;
   logic        repeat_en = 1'b0;
   logic        abort = 1'b0;
   logic        d_out, d_valid, busy, done;

   int checks = 0;
   int failures = 0;
   logic [1:0] sb[$];

   serial_pattern_tx #(.WIDTH(12)) dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
      .repeat_en(repeat_en), .abort(abort), .d_out(d_out), .d_valid(d_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_part(input logic [11:0] p, input int n, input int k);
      for (int i = n - 1; i >= n - k; i--) sb.push_back({(i == 0), p[i]});
   endtask

   task automatic push_pass(input logic [11:0] p, input int n);
      push_part(p, n, n);
   endtask

   task automatic start_tx(input logic [11:0] p, input logic [3:0] l, input logic r);
      pattern = p; len = l; repeat_en = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_vld"}, d_valid, 1'b0);
      chk({name, "_dout"}, d_out, 1'b0);
      chk({name, "_done"}, done, 1'b0);
   endtask

   // Monitor: every valid bit must match the next expected one.
   always @(negedge clk) begin
      if (!rst) begin
         if (d_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_bit", 32'd1, 32'd0);
            end else begin
               logic [1:0] e;
               e = sb.pop_front();
               chk("bit", d_out, e[0]);
               chk("done", done, e[1]);
            end
         end else begin
            chk("idle_outs", {30'b0, d_out, done}, 32'd0);
         end
      end
   end

   initial begin
      #1 rst = 1'b1;
      #1 chk_idle("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Full 12-bit pass, then back-to-back start in the first idle cycle.
      push_pass(12'b010000110111, 12);
      start_tx(12'b010000110111, 4'd12, 1'b0);
      chk("t1_busy", busy, 1'b1);
      repeat (12) @(posedge clk); #1;
      chk_idle("t1_end");

      push_pass(12'h0A5, 4);
      start_tx(12'h0A5, 4'd4, 1'b0);
      repeat (4) @(posedge clk); #1;
      chk_idle("t2_len4");

      push_pass(12'h0A5, 12);
      start_tx(12'h0A5, 4'd0, 1'b0);
      repeat (12) @(posedge clk); #1;
      chk_idle("t2_len0");

      push_pass(12'hC3A, 12);
      start_tx(12'hC3A, 4'd13, 1'b0);
      repeat (12) @(posedge clk); #1;
      chk_idle("t2_len13");

      // Three gapless passes of 3'b110; live inputs change mid-pass and must be ignored.
      repeat (3) push_pass(12'h006, 3);
      start_tx(12'h006, 4'd3, 1'b1);
      pattern = 12'hFFF; len = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk); #1;
      repeat_en = 1'b0;
      @(posedge clk); #1;
      chk_idle("t3_end");

      // Abort on the 5th bit; start while busy must be ignored.
      push_part(12'hB38, 12, 5);
      start_tx(12'hB38, 4'd12, 1'b0);
      pattern = 12'h000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk_idle("t4_abort");
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk_idle("t4_start_abort");

      // Asynchronous reset between edges mid-pass.
      push_part(12'h9A6, 12, 3);
      start_tx(12'h9A6, 4'd12, 1'b0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_idle("t5_async_rst");
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk_idle("t5_post_rst");
      push_pass(12'h02D, 6);
      start_tx(12'h02D, 4'd6, 1'b0);
      repeat (6) @(posedge clk); #1;
      chk_idle("t5_restart");

      // Single-bit pattern with repeat: done every cycle.
      repeat (6) push_pass(12'h001, 1);
      start_tx(12'h001, 4'd1, 1'b1);
      repeat (5) @(posedge clk); #1;
      repeat_en = 1'b0;
      @(posedge clk); #1;
      chk_idle("t6_end");

      repeat (3) @(posedge clk); #1;
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 12: maximum pattern length in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have start  input  1  request to begin transmission; sampled only in IDLE.
REQ-005 SHALL have pattern  input  WIDTH  parallel bit pattern, captured when start is accepted.
REQ-006 SHALL have len  input  4  number of bits to send, captured with pattern; 0 or >WIDTH means WIDTH.
REQ-007 SHALL have repeat_en  input  1  when high at the last bit, transmission restarts with no gap.
REQ-008 SHALL have abort  input  1  stop transmission immediately.
REQ-009 SHALL have d_out  output  1  serial data bit, registered.
REQ-010 SHALL have d_valid  output  1  d_out carries a pattern bit this cycle, registered.
REQ-011 SHALL have busy  output  1  high in SHIFT state.
REQ-012 SHALL have done  output  1  one-cycle pulse coincident with the last bit of each pass.

Function
REQ-013 SHALL implement FSM with states IDLE and SHIFT.
REQ-014 SHALL, in IDLE with start=1 and abort=0 at an edge, capture pattern into a shift register, capture effective length into a length register, load the bit counter with that length, and enter SHIFT.
REQ-015 SHALL present the first bit, pattern[len_eff-1], on d_out with d_valid=1 in the cycle immediately after the accepting edge (latency 1).
REQ-016 SHALL send bits MSB-first of the active field: pattern[len_eff-1] down to pattern[0], one bit per clock, no gaps.
REQ-017 SHALL decrement the bit counter once per transmitted bit; the cycle with counter value 1 is the last bit.
REQ-018 SHALL assert done for exactly that last-bit cycle.
REQ-019 SHALL, at the edge ending the last bit with repeat_en=1, reload the captured (not live) pattern and length and continue in SHIFT; the first bit of the next pass follows the last bit with no idle cycle.
REQ-020 SHALL, at the edge ending the last bit with repeat_en=0, return to IDLE with d_valid=0, d_out=0, busy=0.
REQ-021 SHALL ignore start and changes on pattern/len while in SHIFT.
REQ-022 SHALL, on abort=1 at any edge, enter IDLE at that edge with d_out=0, d_valid=0, busy=0, done=0; abort takes priority over start, last-bit, and repeat.
REQ-023 SHALL, with start and abort both high in IDLE, remain in IDLE.
REQ-024 SHALL drive d_out=0 whenever d_valid=0.
REQ-025 SHALL support len_eff=1: a single bit with d_valid=1 and done=1 in the same cycle; with repeat_en=1, done pulses every cycle.
REQ-026 SHALL accept a new start in the first IDLE cycle after a pass completes (back-to-back transmissions separated by exactly one idle cycle).

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, d_out=0, d_valid=0, busy=0, done=0, shift register and counter to 0, independent of clk.
REQ-028 SHALL, on rst asserted mid-transmission, discard the remaining bits with no done pulse; after release, remain in IDLE until a new start.

Verification
REQ-029 SHALL verify: start with pattern=12'b010000110111, len=12, repeat_en=0 -> d_out 0,1,0,0,0,0,1,1,0,1,1,1 on 12 consecutive cycles, d_valid high throughout, done only on the 12th, IDLE after.
REQ-030 SHALL verify: pattern=12'h0A5, len=4 -> d_out 0,1,0,1; done on 4th bit; len=0 -> 12 bits sent.
REQ-031 SHALL verify: len=3, pattern=3'b110, repeat_en=1 for 3 passes -> 1,1,0,1,1,0,1,1,0 with no gaps, done on every 3rd bit; pattern changed mid-pass has no effect.
REQ-032 SHALL verify: abort asserted on the 5th bit of a 12-bit pass -> d_valid=0 next cycle, no done, busy=0; start while busy ignored.
REQ-033 SHALL verify: rst asserted asynchronously between clock edges mid-pass -> outputs 0 without a clock edge; subsequent start runs normally.
REQ-034 SHALL verify: len=1, pattern bit0=1, repeat_en=1 -> d_out=1 and done=1 every cycle until repeat_en deasserted.
